// File: rtl/philv_mc_controller.sv
// Multi-cycle RV32I control FSM for the philosophy-V datapath.
// Handshaked instruction/data memory with bounded wait, halt/trap states and perf counters.
module philv_mc_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_override,
  output logic             rf_wr,
  output logic [1:0]       rf_src,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT, TRAP} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t           r_state;
  logic [6:0]       r_op;
  logic [TMO_W-1:0] r_wait;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  state_t     w_next;
  logic       w_retire, w_wait_inc, w_expire;
  logic       w_imem_req, w_dmem_req, w_dmem_we, w_ir_wr, w_pc_wr, w_pc_src;
  logic       w_alu_src_a, w_alu_override, w_rf_wr;
  logic [1:0] w_alu_src_b, w_rf_src;

  assign w_expire = (MEM_TIMEOUT > 0) && (r_wait == TMO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next         = r_state;
    w_retire       = 1'b0;
    w_wait_inc     = 1'b0;
    w_imem_req     = 1'b0;
    w_dmem_req     = 1'b0;
    w_dmem_we      = 1'b0;
    w_ir_wr        = 1'b0;
    w_pc_wr        = 1'b0;
    w_pc_src       = 1'b0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = 2'b00;
    w_alu_override = 1'b0;
    w_rf_wr        = 1'b0;
    w_rf_src       = 2'b00;
    case (r_state)
      FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_wr        = 1'b1;
          w_pc_wr        = 1'b1;
          w_alu_src_b    = 2'b01;
          w_alu_override = 1'b1;
          w_next         = DECODE;
        end else if (w_expire) begin
          w_next = TRAP;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      DECODE: begin
        w_alu_src_b    = 2'b10;
        w_alu_override = 1'b1;
        w_next         = EXECUTE;
      end
      EXECUTE: begin
        case (r_op)
          OPC_OP: begin
            w_alu_src_a = 1'b1;
            w_next      = WB;
          end
          OPC_OPIMM: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_next      = WB;
          end
          OPC_LUI, OPC_AUIPC: begin
            w_alu_src_b    = 2'b10;
            w_alu_override = 1'b1;
            w_next         = WB;
          end
          OPC_LOAD, OPC_STORE: begin
            w_alu_src_a    = 1'b1;
            w_alu_src_b    = 2'b10;
            w_alu_override = 1'b1;
            w_next         = MEM;
          end
          OPC_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_pc_wr     = branch_cond;
            w_pc_src    = branch_cond;
            w_retire    = 1'b1;
            w_next      = FETCH;
          end
          OPC_JAL: begin
            w_pc_wr  = 1'b1;
            w_pc_src = 1'b1;
            w_rf_wr  = 1'b1;
            w_rf_src = 2'b10;
            w_retire = 1'b1;
            w_next   = FETCH;
          end
          OPC_JALR: begin
            w_alu_src_a    = 1'b1;
            w_alu_src_b    = 2'b10;
            w_alu_override = 1'b1;
            w_pc_wr        = 1'b1;
            w_rf_wr        = 1'b1;
            w_rf_src       = 2'b10;
            w_retire       = 1'b1;
            w_next         = FETCH;
          end
          OPC_SYSTEM: w_next = HALT;
          default:    w_next = TRAP;
        endcase
      end
      MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_op == OPC_STORE);
        if (dmem_ready) begin
          if (r_op == OPC_STORE) begin
            w_retire = 1'b1;
            w_next   = FETCH;
          end else begin
            w_next = WB;
          end
        end else if (w_expire) begin
          w_next = TRAP;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      WB: begin
        w_rf_wr  = 1'b1;
        w_rf_src = (r_op == OPC_LOAD) ? 2'b00 : 2'b01;
        w_retire = 1'b1;
        w_next   = FETCH;
      end
      default: w_next = r_state;
    endcase
  end

  // Wait counter is zero outside waiting cycles, so entry into FETCH/MEM always starts from 0.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state   <= FETCH;
      r_op      <= '0;
      r_wait    <= '0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_inc ? r_wait + 1'b1 : '0;
      if (w_ir_wr)
        r_op <= opcode;
      if (r_state != HALT && r_state != TRAP)
        r_cycle <= r_cycle + 1'b1;
      if (w_retire)
        r_instret <= r_instret + 1'b1;
    end
  end

  assign imem_req     = rstb & w_imem_req;
  assign dmem_req     = rstb & w_dmem_req;
  assign dmem_we      = rstb & w_dmem_we;
  assign ir_wr        = rstb & w_ir_wr;
  assign pc_wr        = rstb & w_pc_wr;
  assign pc_src       = rstb & w_pc_src;
  assign alu_src_a    = rstb & w_alu_src_a;
  assign alu_src_b    = rstb ? w_alu_src_b : '0;
  assign alu_override = rstb & w_alu_override;
  assign rf_wr        = rstb & w_rf_wr;
  assign rf_src       = rstb ? w_rf_src : '0;
  assign halted       = (r_state == HALT);
  assign trap         = (r_state == TRAP);
  assign cycle_cnt    = r_cycle;
  assign instret      = r_instret;

endmodule

// File: tb/tb_philv_mc_controller.sv
// Scoreboard bench for philv_mc_controller: directed per-cycle vectors queued by the
// stimulus process, popped and compared by an independent monitor on the falling edge.
module tb_philv_mc_controller;

  logic       clk = 1'b0;
  logic       rstb;
  logic [6:0] opcode;
  logic       branch_cond, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, ir_wr, pc_wr, pc_src, alu_src_a;
  logic [1:0] alu_src_b, rf_src;
  logic       alu_override, rf_wr, halted, trap;
  logic [3:0] cycle_cnt, instret;

  philv_mc_controller #(.CNT_W(4), .MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .clk(clk), .rstb(rstb), .opcode(opcode), .branch_cond(branch_cond),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_override(alu_override), .rf_wr(rf_wr), .rf_src(rf_src),
    .halted(halted), .trap(trap), .cycle_cnt(cycle_cnt), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] SYS = 7'b1110011, BAD = 7'b1111111;

  // Field order: imem_req dmem_req dmem_we ir_wr pc_wr pc_src a b[1:0] override rf_wr rf_src[1:0] halted trap
  localparam logic [14:0] E_0    = 15'b0_0_0_0_0_0_0_00_0_0_00_0_0;
  localparam logic [14:0] E_FW   = 15'b1_0_0_0_0_0_0_00_0_0_00_0_0;
  localparam logic [14:0] E_FR   = 15'b1_0_0_1_1_0_0_01_1_0_00_0_0;
  localparam logic [14:0] E_DEC  = 15'b0_0_0_0_0_0_0_10_1_0_00_0_0;
  localparam logic [14:0] E_EXOP = 15'b0_0_0_0_0_0_1_00_0_0_00_0_0;
  localparam logic [14:0] E_EXIM = 15'b0_0_0_0_0_0_1_10_0_0_00_0_0;
  localparam logic [14:0] E_EXU  = 15'b0_0_0_0_0_0_0_10_1_0_00_0_0;
  localparam logic [14:0] E_EXLS = 15'b0_0_0_0_0_0_1_10_1_0_00_0_0;
  localparam logic [14:0] E_BRT  = 15'b0_0_0_0_1_1_1_00_0_0_00_0_0;
  localparam logic [14:0] E_JAL  = 15'b0_0_0_0_1_1_0_00_0_1_10_0_0;
  localparam logic [14:0] E_JALR = 15'b0_0_0_0_1_0_1_10_1_1_10_0_0;
  localparam logic [14:0] E_MLD  = 15'b0_1_0_0_0_0_0_00_0_0_00_0_0;
  localparam logic [14:0] E_MST  = 15'b0_1_1_0_0_0_0_00_0_0_00_0_0;
  localparam logic [14:0] E_WBOP = 15'b0_0_0_0_0_0_0_00_0_1_01_0_0;
  localparam logic [14:0] E_WBLD = 15'b0_0_0_0_0_0_0_00_0_1_00_0_0;
  localparam logic [14:0] E_HALT = 15'b0_0_0_0_0_0_0_00_0_0_00_1_0;
  localparam logic [14:0] E_TRAP = 15'b0_0_0_0_0_0_0_00_0_0_00_0_1;

  typedef struct packed {
    logic [14:0] v;
    logic        cc;
    logic [3:0]  cy;
    logic [3:0]  rt;
    int          tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic step(input logic [6:0] opc, input logic ir, input logic dr, input logic bc,
                      input logic rb, input logic [14:0] e, input int tag,
                      input logic cc, input int cy, input int rt);
    exp_t x;
    @(posedge clk);
    #1;
    opcode = opc; imem_ready = ir; dmem_ready = dr; branch_cond = bc; rstb = rb;
    x.v = e; x.cc = cc; x.cy = 4'(cy); x.rt = 4'(rt); x.tag = tag;
    q.push_back(x);
  endtask

  task automatic st(input logic [6:0] opc, input logic ir, input logic dr, input logic bc,
                    input logic [14:0] e, input int tag);
    step(opc, ir, dr, bc, 1'b1, e, tag, 1'b0, 0, 0);
  endtask

  task automatic stc(input logic [6:0] opc, input logic ir, input logic dr, input logic bc,
                     input logic [14:0] e, input int tag, input int cy, input int rt);
    step(opc, ir, dr, bc, 1'b1, e, tag, 1'b1, cy, rt);
  endtask

  task automatic rs(input logic [14:0] e, input int tag);
    step(OP, 1'b1, 1'b1, 1'b0, 1'b0, e, tag, 1'b0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [14:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {imem_req, dmem_req, dmem_we, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
             alu_override, rf_wr, rf_src, halted, trap};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL outputs tag=%0d got=%b exp=%b", e.tag, act, e.v);
      end
      if (e.cc) begin
        checks++;
        if (cycle_cnt !== e.cy || instret !== e.rt) begin
          errors++;
          $display("FAIL counters tag=%0d got cyc=%0d ret=%0d exp cyc=%0d ret=%0d",
                   e.tag, cycle_cnt, instret, e.cy, e.rt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0; opcode = OP; imem_ready = 1'b1; dmem_ready = 1'b1; branch_cond = 1'b0;
    @(posedge clk);
    step(OP, 1'b1, 1'b1, 1'b0, 1'b0, E_0, 1, 1'b1, 0, 0);

    // Back-to-back OP with zero-wait memory
    for (int i = 0; i < 2; i++) begin
      stc(OP, 1, 1, 0, E_FR,   100 + 4*i, 4*i, i);
      st (OP, 1, 1, 0, E_DEC,  101 + 4*i);
      st (OP, 1, 1, 0, E_EXOP, 102 + 4*i);
      st (OP, 1, 1, 0, E_WBOP, 103 + 4*i);
    end

    // LOAD with three wait cycles; opcode input changes after the latch must be ignored
    stc(LD, 1, 1, 0, E_FR,   200, 8, 2);
    st (LD, 1, 1, 0, E_DEC,  201);
    st (LD, 1, 1, 0, E_EXLS, 202);
    st (ST, 1, 0, 0, E_MLD,  203);
    st (ST, 1, 0, 0, E_MLD,  204);
    st (ST, 1, 0, 0, E_MLD,  205);
    st (ST, 1, 1, 0, E_MLD,  206);
    stc(ST, 1, 1, 0, E_WBLD, 207, 15, 2);

    // Branch taken / not taken, JAL, JALR, STORE, OP-IMM, LUI, AUIPC with a fetch stall
    stc(BR, 1, 1, 0, E_FR,   300, 0, 3);
    st (BR, 1, 1, 0, E_DEC,  301);
    st (BR, 1, 1, 1, E_BRT,  302);
    stc(BR, 1, 1, 0, E_FR,   303, 3, 4);
    st (BR, 1, 1, 0, E_DEC,  304);
    st (BR, 1, 1, 0, E_EXOP, 305);
    stc(JAL, 1, 1, 0, E_FR,  306, 6, 5);
    st (JAL, 1, 1, 0, E_DEC, 307);
    st (JAL, 1, 1, 0, E_JAL, 308);
    stc(JALR, 1, 1, 0, E_FR, 309, 9, 6);
    st (JALR, 1, 1, 0, E_DEC, 310);
    st (JALR, 1, 1, 0, E_JALR, 311);
    stc(ST, 1, 1, 0, E_FR,   312, 12, 7);
    st (ST, 1, 1, 0, E_DEC,  313);
    st (ST, 1, 1, 0, E_EXLS, 314);
    st (ST, 1, 1, 0, E_MST,  315);
    stc(OPI, 1, 1, 0, E_FR,  316, 0, 8);
    st (OPI, 1, 1, 0, E_DEC, 317);
    st (OPI, 1, 1, 0, E_EXIM, 318);
    st (OPI, 1, 1, 0, E_WBOP, 319);
    stc(LUI, 1, 1, 0, E_FR,  320, 4, 9);
    st (LUI, 1, 1, 0, E_DEC, 321);
    st (LUI, 1, 1, 0, E_EXU, 322);
    st (LUI, 1, 1, 0, E_WBOP, 323);
    stc(AUI, 0, 1, 0, E_FW,  324, 8, 10);
    st (AUI, 1, 1, 0, E_FR,  325);
    st (AUI, 1, 1, 0, E_DEC, 326);
    st (AUI, 1, 1, 0, E_EXU, 327);
    st (AUI, 1, 1, 0, E_WBOP, 328);

    // SYSTEM halts; counters freeze for 20 cycles
    stc(SYS, 1, 1, 0, E_FR,  400, 13, 11);
    st (SYS, 1, 1, 0, E_DEC, 401);
    st (SYS, 1, 1, 0, E_0,   402);
    for (int i = 0; i < 20; i++)
      stc(SYS, 1, 1, 0, E_HALT, 410 + i, 0, 11);
    rs(E_HALT, 430);

    // Illegal opcode traps
    stc(BAD, 1, 1, 0, E_FR,  500, 0, 0);
    st (BAD, 1, 1, 0, E_DEC, 501);
    st (BAD, 1, 1, 0, E_0,   502);
    stc(BAD, 1, 1, 0, E_TRAP, 503, 3, 0);
    stc(OP,  1, 1, 0, E_TRAP, 504, 3, 0);
    rs(E_TRAP, 505);

    // Fetch timeout at MEM_TIMEOUT=4, then reset clears trap
    for (int i = 0; i < 4; i++)
      stc(OP, 0, 1, 0, E_FW, 600 + i, i, 0);
    stc(OP, 0, 1, 0, E_TRAP, 604, 4, 0);
    stc(OP, 1, 1, 0, E_TRAP, 605, 4, 0);
    rs(E_TRAP, 606);
    stc(OP, 0, 1, 0, E_FW, 607, 0, 0);

    // Data-memory timeout
    st (LD, 1, 0, 0, E_FR,   700);
    st (LD, 1, 0, 0, E_DEC,  701);
    st (LD, 1, 0, 0, E_EXLS, 702);
    for (int i = 0; i < 4; i++)
      st(LD, 1, 0, 0, E_MLD, 703 + i);
    stc(LD, 1, 0, 0, E_TRAP, 707, 8, 0);
    rs(E_TRAP, 708);

    // 17 OP instructions wrap the 4-bit counters
    for (int i = 0; i < 17; i++) begin
      st(OP, 1, 1, 0, E_FR,   800 + 4*i);
      st(OP, 1, 1, 0, E_DEC,  801 + 4*i);
      st(OP, 1, 1, 0, E_EXOP, 802 + 4*i);
      st(OP, 1, 1, 0, E_WBOP, 803 + 4*i);
    end

    // Reset during a STORE's MEM cycle drops the request immediately
    stc(ST, 1, 1, 0, E_FR,   900, 4, 1);
    st (ST, 1, 1, 0, E_DEC,  901);
    st (ST, 1, 1, 0, E_EXLS, 902);
    st (ST, 1, 0, 0, E_MST,  903);
    step(ST, 1'b1, 1'b1, 1'b0, 1'b0, E_0, 904, 1'b0, 0, 0);
    stc(OP, 1, 1, 0, E_FR,   905, 0, 0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
